micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Next-state engine for the microprogrammed control unit. Holds the 7-bit state register
//  that addresses the microstore and computes each next state from the microstore's
//  sequencing fields, the instruction register and the status inputs. Sits between the
//  microstore (consumes its next-state fields, drives its state input) and the datapath.
// PARAMETERS
//  STATE_W     7    width of the state address
//  WAIT_LIMIT  15   max consecutive cycles held in a WAIT microinstruction before abort
//  ABORT_STATE 1    state entered on wait timeout and on undecodable instructions
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high reset
//  ns_mode        in   3      next-state mode from microstore (encoding below)
//  cr_addr        in   7      branch target field from microstore
//  cond_sel       in   2      condition source: 00 moc, 01 br_cond, 10 const 0, 11 const 1
//  cond_inv       in   1      invert the selected condition
//  moc            in   1      memory operation complete
//  br_cond        in   1      branch condition from ALU/comparator
//  ir             in   32     instruction register contents
//  current_state  out  7      registered state, drives microstore address
//  timeout        out  1      one-cycle pulse when a wait is aborted
// BEHAVIOUR
//  - Reset: current_state=0, wait counter=0, timeout=0. Reset beats every other input.
//  - cond = mux(cond_sel) ^ cond_inv. Next state is registered on every rising clk.
//  - ns_mode: 000 DECODE  next = encoder(ir)
//             001 FETCH   next = 1
//             010 INCR    next = current_state+1 (7-bit wrap, 127 -> 0)
//             011 JUMP    next = cr_addr
//             100 CBRANCH next = cond ? cr_addr : current_state+1
//             101 WAIT    next = cond ? current_state+1 : current_state
//             110 HOLD    next = current_state (unconditional)
//             111 RESET   next = 0
//  - Wait counter: increments each cycle WAIT is selected with cond=0; cleared in any
//    other cycle. When counter == WAIT_LIMIT-1 and cond=0: next = ABORT_STATE,
//    timeout=1 for that one cycle (registered with the state), counter cleared.
//    cond=1 on the limit cycle wins: normal advance, no timeout.
//  - timeout registered; 0 in every cycle other than the abort transition.
//  - Encoder (combinational): opcode ir[31:26], funct ir[5:0] for R-type:
//    R-type addu (funct 0x21) -> 6; lw (0x23) -> 7; sw (0x2B) -> 13; beq (0x04) -> 12;
//    remaining supported opcodes per package table; any unlisted encoding -> ABORT_STATE.
//  - Latency: one cycle from inputs to current_state; no combinational path to outputs.
//  - Reset mid-wait or mid-branch: state 0 next cycle, counter and timeout cleared.
// STRUCTURE
//  - Package ctrl_pkg: ns_mode encodings, cond_sel encodings, opcode/funct constants,
//    opcode->state table, ABORT_STATE/FETCH_STATE constants shared with the microstore.
//  - One sub-module: instr_encoder (ir -> 7-bit entry state, purely combinational).
//  - Top: condition mux, next-state mux, state register, wait counter, timeout flop.
// TESTING
//  1 reset=1 with ns_mode=011, cr_addr=40 -> current_state=0, timeout=0 on next edge.
//  2 ns_mode=000, ir opcode 0x23 -> state 7; ir opcode 0x3F (undefined) -> state 1;
//    R-type funct 0x21 -> state 6.
//  3 ns_mode=101, cond_sel=00, moc=0 for 3 cycles then 1 -> state held 3 cycles, then +1.
//  4 ns_mode=101, moc stuck 0, WAIT_LIMIT=15 -> held 14 cycles, then state=1, timeout
//    high exactly one cycle; moc=1 on limit cycle instead -> state+1, no timeout.
//  5 ns_mode=100, cr_addr=20, br_cond=1, cond_inv=0 -> 20; cond_inv=1 -> state+1;
//    state 127 with ns_mode=010 -> 0.
//  6 reset asserted during a wait at count 10 -> state 0; after release a fresh wait
//    runs the full 14 held cycles before abort.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared constants for the microprogrammed control unit: next-state mode
//   and condition-select encodings, opcode/funct values, the instruction ->
//   microstore entry-state tables, and the well-known microstore addresses
//   (FETCH_STATE, ABORT_STATE) that the microstore contents rely on.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int CTRL_STATE_W = 7;

  // Well-known microstore addresses.
  localparam logic [CTRL_STATE_W-1:0] RESET_STATE = 7'd0;
  localparam logic [CTRL_STATE_W-1:0] FETCH_STATE = 7'd1;
  localparam logic [CTRL_STATE_W-1:0] ABORT_STATE = 7'd1;

  // Next-state mode field of the microinstruction.
  localparam logic [2:0] NS_DECODE  = 3'b000;
  localparam logic [2:0] NS_FETCH   = 3'b001;
  localparam logic [2:0] NS_INCR    = 3'b010;
  localparam logic [2:0] NS_JUMP    = 3'b011;
  localparam logic [2:0] NS_CBRANCH = 3'b100;
  localparam logic [2:0] NS_WAIT    = 3'b101;
  localparam logic [2:0] NS_HOLD    = 3'b110;
  localparam logic [2:0] NS_RESET   = 3'b111;

  // Condition source select.
  localparam logic [1:0] CS_MOC    = 2'b00;
  localparam logic [1:0] CS_BRCOND = 2'b01;
  localparam logic [1:0] CS_ZERO   = 2'b10;
  localparam logic [1:0] CS_ONE    = 2'b11;

  // Primary opcodes (ir[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ir[5:0]).
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // One row of a decode table: code to match and the microstore entry state.
  typedef struct packed {
    logic [5:0]              code;
    logic [CTRL_STATE_W-1:0] state;
  } dec_entry_t;

  localparam int N_OP_ENTRIES = 8;
  localparam int N_FN_ENTRIES = 6;

  // Non-R-type opcodes -> entry state. OP_RTYPE must not appear here.
  localparam dec_entry_t [N_OP_ENTRIES-1:0] OP_TABLE = {
    {OP_LW,    7'd7},
    {OP_ADDIU, 7'd8},
    {OP_ORI,   7'd9},
    {OP_LUI,   7'd10},
    {OP_J,     7'd11},
    {OP_BEQ,   7'd12},
    {OP_SW,    7'd13},
    {OP_BNE,   7'd14}
  };

  // R-type function codes -> entry state.
  localparam dec_entry_t [N_FN_ENTRIES-1:0] FN_TABLE = {
    {FN_ADDU, 7'd6},
    {FN_SUBU, 7'd18},
    {FN_AND,  7'd19},
    {FN_OR,   7'd20},
    {FN_SLT,  7'd21},
    {FN_JR,   7'd22}
  };

endpackage

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Purely combinational map from the instruction register to the microstore
//   entry state for that instruction. Anything not in the decode tables
//   (unknown opcode, or R-type with unknown funct) maps to ABORT_STATE.
// Ports
//   ir           in   32       instruction register
//   entry_state  out  STATE_W  microstore entry address for the instruction
// ---------------------------------------------------------------------------
module instr_encoder
  import ctrl_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int ABORT_STATE = 1
) (
  input  logic [31:0]        ir,
  output logic [STATE_W-1:0] entry_state
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode         = ir[31:26];
  assign funct          = ir[5:0];
  // Register/immediate fields carry no sequencing information.
  assign unused_ir_bits = ^ir[25:6];

  logic [N_OP_ENTRIES-1:0] op_hit;
  logic [N_FN_ENTRIES-1:0] fn_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_OP_ENTRIES; gi++) begin : g_op_match
      assign op_hit[gi] = (opcode == OP_TABLE[gi].code);
    end
    for (gi = 0; gi < N_FN_ENTRIES; gi++) begin : g_fn_match
      assign fn_hit[gi] = (opcode == OP_RTYPE) && (funct == FN_TABLE[gi].code);
    end
  endgenerate

  // Table codes are unique, so at most one hit is active; the loop order
  // only matters for building a mux, not for priority.
  always_comb begin
    entry_state = STATE_W'(ABORT_STATE);
    for (int i = 0; i < N_OP_ENTRIES; i++) begin
      if (op_hit[i]) entry_state = STATE_W'(OP_TABLE[i].state);
    end
    for (int i = 0; i < N_FN_ENTRIES; i++) begin
      if (fn_hit[i]) entry_state = STATE_W'(FN_TABLE[i].state);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//   Next-state engine of the microprogrammed control unit. Holds the state
//   register that addresses the microstore and computes the next state from
//   the microinstruction's sequencing fields, the instruction register and
//   the status inputs. A WAIT microinstruction that stalls too long is
//   aborted to ABORT_STATE with a one-cycle timeout pulse.
// Ports
//   clk            in   1        rising-edge clock
//   reset          in   1        synchronous active-high reset
//   ns_mode        in   3        next-state mode (NS_* in ctrl_pkg)
//   cr_addr        in   STATE_W  branch/jump target
//   cond_sel       in   2        condition source (CS_* in ctrl_pkg)
//   cond_inv       in   1        invert selected condition
//   moc            in   1        memory operation complete
//   br_cond        in   1        branch condition from datapath
//   ir             in   32       instruction register
//   current_state  out  STATE_W  registered state / microstore address
//   timeout        out  1        registered pulse on wait abort
// ---------------------------------------------------------------------------
module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int WAIT_LIMIT  = 15,
  parameter int ABORT_STATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_mode,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic               moc,
  input  logic               br_cond,
  input  logic [31:0]        ir,
  output logic [STATE_W-1:0] current_state,
  output logic               timeout
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;

  logic [STATE_W-1:0] entry_state;
  logic [STATE_W-1:0] state_inc;
  logic               cond_raw;
  logic               cond;

  instr_encoder #(
    .STATE_W     (STATE_W),
    .ABORT_STATE (ABORT_STATE)
  ) u_encoder (
    .ir          (ir),
    .entry_state (entry_state)
  );

  always_comb begin
    cond_raw = 1'b0;
    case (cond_sel)
      CS_MOC:    cond_raw = moc;
      CS_BRCOND: cond_raw = br_cond;
      CS_ZERO:   cond_raw = 1'b0;
      CS_ONE:    cond_raw = 1'b1;
      default:   cond_raw = 1'b0;
    endcase
  end

  assign cond      = cond_raw ^ cond_inv;
  // Natural STATE_W-bit wrap: the last microstore address increments to 0.
  assign state_inc = state_q + STATE_W'(1);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;      // counter only survives consecutive stalled WAITs
    timeout_d = 1'b0;
    case (ns_mode)
      NS_DECODE:  state_d = entry_state;
      NS_FETCH:   state_d = STATE_W'(FETCH_STATE);
      NS_INCR:    state_d = state_inc;
      NS_JUMP:    state_d = cr_addr;
      NS_CBRANCH: state_d = cond ? cr_addr : state_inc;
      NS_WAIT: begin
        if (cond) begin
          // Condition arriving on the limit cycle still advances normally.
          state_d = state_inc;
        end else if (wcnt_q == WCNT_W'(WAIT_LIMIT - 1)) begin
          state_d   = STATE_W'(ABORT_STATE);
          timeout_d = 1'b1;
        end else begin
          state_d = state_q;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      NS_HOLD:    state_d = state_q;
      NS_RESET:   state_d = STATE_W'(RESET_STATE);
      default:    state_d = STATE_W'(RESET_STATE);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign current_state = state_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ns_mode;
  logic [6:0]  cr_addr;
  logic [1:0]  cond_sel;
  logic        cond_inv;
  logic        moc;
  logic        br_cond;
  logic [31:0] ir;
  logic [6:0]  current_state;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  micro_sequencer #(
    .STATE_W     (7),
    .WAIT_LIMIT  (15),
    .ABORT_STATE (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ns_mode       (ns_mode),
    .cr_addr       (cr_addr),
    .cond_sel      (cond_sel),
    .cond_inv      (cond_inv),
    .moc           (moc),
    .br_cond       (br_cond),
    .ir            (ir),
    .current_state (current_state),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [6:0] tgt);
    ns_mode = NS_JUMP;
    cr_addr = tgt;
    step();
    chk("jump", int'(current_state), int'(tgt));
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h5A5A5, fn};
  endfunction

  // Directed decode vectors: opcode, funct, expected entry state.
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         exp;
  } dec_vec_t;

  dec_vec_t dec_vecs[7];

  initial begin
    dec_vecs[0] = '{6'h23, 6'h00, 7};   // lw
    dec_vecs[1] = '{6'h3F, 6'h00, 1};   // undefined opcode
    dec_vecs[2] = '{6'h00, 6'h21, 6};   // addu
    dec_vecs[3] = '{6'h2B, 6'h21, 13};  // sw (funct ignored)
    dec_vecs[4] = '{6'h04, 6'h00, 12};  // beq
    dec_vecs[5] = '{6'h00, 6'h3F, 1};   // R-type unknown funct
    dec_vecs[6] = '{6'h00, 6'h23, 18};  // subu

    reset = 1'b1; ns_mode = NS_JUMP; cr_addr = 7'd40;
    cond_sel = CS_MOC; cond_inv = 1'b0; moc = 1'b0; br_cond = 1'b0; ir = '0;
    #1;

    // 1: reset beats a JUMP
    step();
    chk("reset_state", int'(current_state), 0);
    chk("reset_timeout", int'(timeout), 0);
    reset = 1'b0;

    // 2: decode
    foreach (dec_vecs[i]) begin
      ns_mode = NS_DECODE;
      ir = mk_ir(dec_vecs[i].op, dec_vecs[i].fn);
      step();
      chk($sformatf("decode_op%02h_fn%02h", dec_vecs[i].op, dec_vecs[i].fn),
          int'(current_state), dec_vecs[i].exp);
    end

    // misc modes
    jump_to(7'd77);
    ns_mode = NS_FETCH; step(); chk("fetch", int'(current_state), 1);
    jump_to(7'd33);
    ns_mode = NS_HOLD; step(); chk("hold", int'(current_state), 33);
    ns_mode = NS_INCR; step(); chk("incr", int'(current_state), 34);
    ns_mode = NS_RESET; step(); chk("reset_mode", int'(current_state), 0);

    // 3: short wait on moc
    jump_to(7'd30);
    ns_mode = NS_WAIT; cond_sel = CS_MOC; cond_inv = 1'b0; moc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wait_hold%0d", k), int'(current_state), 30);
    end
    moc = 1'b1; step();
    chk("wait_done", int'(current_state), 31);
    chk("wait_done_to", int'(timeout), 0);

    // 4a: wait timeout
    jump_to(7'd40);
    ns_mode = NS_WAIT; moc = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      chk($sformatf("to_hold%0d", k), int'(current_state), 40);
      chk($sformatf("to_hold_to%0d", k), int'(timeout), 0);
    end
    step();
    chk("to_abort_state", int'(current_state), 1);
    chk("to_abort_pulse", int'(timeout), 1);
    ns_mode = NS_HOLD; step();
    chk("to_pulse_end", int'(timeout), 0);
    chk("to_after_state", int'(current_state), 1);

    // 4b: moc arrives on the limit cycle
    jump_to(7'd50);
    ns_mode = NS_WAIT; moc = 1'b0;
    for (int k = 0; k < 14; k++) step();
    chk("lim_held", int'(current_state), 50);
    moc = 1'b1; step();
    chk("lim_advance", int'(current_state), 51);
    chk("lim_no_to", int'(timeout), 0);

    // 5: conditional branch and wrap
    jump_to(7'd10);
    ns_mode = NS_CBRANCH; cr_addr = 7'd20; cond_sel = CS_BRCOND; br_cond = 1'b1; cond_inv = 1'b0;
    step(); chk("cbr_taken", int'(current_state), 20);
    cond_inv = 1'b1;
    step(); chk("cbr_inv_not_taken", int'(current_state), 21);
    cond_sel = CS_ZERO; cond_inv = 1'b1;
    step(); chk("cbr_zero_inv", int'(current_state), 20);
    cond_sel = CS_ONE; cond_inv = 1'b1; cr_addr = 7'd90;
    step(); chk("cbr_one_inv", int'(current_state), 21);
    cond_inv = 1'b0;
    jump_to(7'd127);
    ns_mode = NS_INCR; step();
    chk("incr_wrap", int'(current_state), 0);

    // 6: reset mid-wait, then a fresh full wait from state 0
    cond_sel = CS_MOC; cond_inv = 1'b0; moc = 1'b0;
    jump_to(7'd60);
    ns_mode = NS_WAIT;
    for (int k = 0; k < 10; k++) step();
    chk("mid_wait_state", int'(current_state), 60);
    reset = 1'b1; step();
    chk("mid_reset_state", int'(current_state), 0);
    chk("mid_reset_to", int'(timeout), 0);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      chk($sformatf("fresh_hold%0d", k), int'(current_state), 0);
    end
    step();
    chk("fresh_abort_state", int'(current_state), 1);
    chk("fresh_abort_pulse", int'(timeout), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
